multi_debounce: RTL and testbench
=================================

# multi_debounce

Parametrised multi-channel pushbutton debouncer for the board input path. It samples CH raw button inputs on an internally generated sample tick, so the whole block runs on the single system clock. Each channel gets a stable level plus one-cycle press and release strobes. An optional hold detector flags long presses. Downstream game and menu logic consume the strobes directly instead of building their own edge detectors.

## Interface
- CH, 4: number of independent button channels (≥1)
- DEPTH, 8: consecutive identical samples needed to change state (≥2)
- TICK_DIV, 100000: clk cycles per sample tick (≥1; 100000 = 1 ms at 100 MHz)
- HOLD_TICKS, 500: ticks of continuous pressed level before hold asserts (≥1; used only with hold feature)
- clk  in  1  system clock; every register is on its rising edge
- rst  in  1  synchronous, active-high reset
- button  in  CH  raw, asynchronous, bouncing inputs; 1 = pressed
- level  out  CH  debounced state per channel
- press  out  CH  one-clk pulse when level goes 0→1
- release  out  CH  one-clk pulse when level goes 1→0
- hold  out  CH  long-press flag (see Configuration)
- tick  out  1  sample strobe, exported for debug and bench alignment

## Operation
- Synchroniser: two flip-flops per channel on button. The second-stage output is sync[i]. Both stages reset to 0.
- Tick generator:
  - Counter width is $clog2(TICK_DIV), minimum 1.
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is combinational and equals (count == TICK_DIV-1).
  - With TICK_DIV=1, tick is constantly 1 outside reset.
- Per-channel shift register sh[i], DEPTH bits:
  - On a tick cycle, next sh = {sh[DEPTH-2:0], sync[i]}. Otherwise it holds.
- Level update, on the tick edge, using the next shift value:
  - If next sh is all ones and level=0: level←1 and press←1.
  - If next sh is all zeros and level=1: level←0 and release←1.
  - Otherwise level holds.
- press and release are 1 for exactly one clk cycle, then return to 0 on the next edge.
- Channels are fully independent. Any combination of channels may strobe in the same cycle.
- A bouncing input that never produces DEPTH identical consecutive samples leaves level unchanged and emits no strobes.

## Timing
- Reset values: level=0, press=0, release=0, hold=0, tick=0, sh=0, tick counter=0, hold counters=0, synchroniser=0.
- After rst deasserts, the first tick is in the TICK_DIV-th cycle.
- Latency from a clean input edge to the level change:
  - 2 clk cycles through the synchroniser.
  - Then DEPTH ticks: level changes at the edge closing the DEPTH-th tick that samples the new value.
  - Worst case: 2 + DEPTH·TICK_DIV clk cycles.
- The press or release pulse is registered on the same edge as the level change. It is visible in the cycle after that edge.
- Reset mid-operation:
  - All state clears on the edge where rst=1.
  - No release pulse is emitted even if level was 1.
  - rst overrides any coincident tick.
- Sampling restarts from an empty (all-zero) shift history after reset. A button held through reset produces a press DEPTH ticks after release of rst.

## Configuration
- Macro: DEBOUNCE_HOLD_EN.
- Defined:
  - Each channel has a saturating hold counter of width $clog2(HOLD_TICKS+1).
  - The counter increments on each tick while level=1.
  - It clears to 0 on the edge where level falls, and whenever level=0.
  - hold[i] is 1 while the counter equals HOLD_TICKS.
  - hold[i] clears on the same edge that level falls.
- Undefined: hold is tied to 0, and the hold counters and the HOLD_TICKS logic are not synthesised. All other behaviour is identical.

## Test plan
Use CH=2, DEPTH=4, TICK_DIV=4, HOLD_TICKS=3, DEBOUNCE_HOLD_EN defined.
- Reset:
  - Stimulus: hold rst=1 for 3 cycles with button=2'b11, then release rst.
  - Required: all outputs 0 during reset. The first tick occurs in the 4th cycle after release.
  - Required: level[1:0]=2'b11 with press=2'b11 for one cycle after the 4th tick.
- Clean press:
  - Stimulus: button[0] 0→1 and held.
  - Required: level[0] rises after the 4th tick that samples 1, with press[0] high for exactly 1 cycle.
  - Required: release, level[1] and press[1] stay 0.
- Bounce rejection:
  - Stimulus: button[0] toggles every 6 clk for 60 clk, then settles at 0.
  - Required: level[0]=0 throughout, and press and release never assert.
- Release and hold:
  - Stimulus: after a clean press, keep button[0]=1 for 3 more ticks, then drop it to 0.
  - Required: hold[0]=1 after the 3rd tick.
  - Required: 4 ticks after the drop, level[0] and hold[0] fall together and release[0] pulses for 1 cycle.
- Simultaneous channels:
  - Stimulus: button=2'b11 applied in the same cycle.
  - Required: press=2'b11 in the same single cycle and level=2'b11.
- Reset mid-press:
  - Stimulus: assert rst for 1 cycle while level[0]=1 and hold[0]=1.
  - Required: level, hold and the counters go to 0 with no release pulse.
  - Required: with the button still held, press[0] recurs 4 ticks later.

Source files
------------

// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - multi-channel pushbutton debouncer with shared sample tick; hold detect via DEBOUNCE_HOLD_EN
module multi_debounce #(
    parameter int CH         = 4,
    parameter int DEPTH      = 8,
    parameter int TICK_DIV   = 100000,
    parameter int HOLD_TICKS = 500
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] button,
    output logic [CH-1:0] level,
    output logic [CH-1:0] press,
    output logic [CH-1:0] release_pulse,
    output logic [CH-1:0] hold,
    output logic          tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CH-1:0]    sync1;
    logic [CH-1:0]    sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Gated by rst so a reset cycle never counts as a sample, even with TICK_DIV=1.
    assign tick = !rst && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < CH; i++) begin : g_ch
            logic [DEPTH-1:0] sh;
            logic [DEPTH-1:0] sh_next;
            logic             lvl;
            logic             prs;
            logic             rel;
            logic             rise;
            logic             fall;

            assign sh_next = {sh[DEPTH-2:0], sync2[i]};
            assign rise    = tick && (&sh_next) && !lvl;
            assign fall    = tick && !(|sh_next) && lvl;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sh  <= '0;
                    lvl <= 1'b0;
                    prs <= 1'b0;
                    rel <= 1'b0;
                end else begin
                    if (tick) begin
                        sh <= sh_next;
                    end
                    if (rise) begin
                        lvl <= 1'b1;
                    end else if (fall) begin
                        lvl <= 1'b0;
                    end
                    prs <= rise;
                    rel <= fall;
                end
            end

            assign level[i]         = lvl;
            assign press[i]         = prs;
            assign release_pulse[i] = rel;

`ifdef DEBOUNCE_HOLD_EN
            localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
            logic [HOLD_W-1:0] hcnt;

            // Saturates at HOLD_MAX; cleared on the falling edge and whenever released.
            always_ff @(posedge clk) begin
                if (rst || fall || !lvl) begin
                    hcnt <= '0;
                end else if (tick && (hcnt != HOLD_MAX)) begin
                    hcnt <= hcnt + 1'b1;
                end
            end

            assign hold[i] = (hcnt == HOLD_MAX);
`else
            assign hold[i] = 1'b0;
`endif
        end
    endgenerate

`ifndef DEBOUNCE_HOLD_EN
    // HOLD_TICKS has no effect without the hold feature; this keeps it referenced.
    if (HOLD_TICKS < 1) begin : g_hold_ticks_unused
    end
`endif

endmodule

// File: tb/tb_multi_debounce.sv
// tb/tb_multi_debounce.sv - randomized bench for multi_debounce against a run-length behavioural model
module tb_multi_debounce;
    localparam int CH         = 2;
    localparam int DEPTH      = 4;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 3;
`ifdef DEBOUNCE_HOLD_EN
    localparam logic [1:0] HOLD_ON = 2'b11;
`else
    localparam logic [1:0] HOLD_ON = 2'b00;
`endif

    logic          clk;
    logic          rst;
    logic [CH-1:0] button;
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] hold;
    logic          tick;

    int checks   = 0;
    int failures = 0;

    multi_debounce #(
        .CH(CH), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .level(level), .press(press),
        .release_pulse(release_pulse), .hold(hold), .tick(tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: a channel's level follows the sampled value once the current run
    // of identical samples reaches DEPTH; history starts as a full run of zeros.
    logic          rst_q = 1'b1;
    logic [CH-1:0] btn_q = '0;
    int            m_cyc = 0;
    bit            m_s1[CH];
    bit            m_s2[CH];
    bit            m_run_val[CH];
    int            m_run_len[CH];
    bit            m_level[CH];
    bit            m_press[CH];
    bit            m_rel[CH];
    int            m_hcnt[CH];
    bit            tick_now;
    bit            was;
    logic [CH-1:0] e_level, e_press, e_rel, e_hold;

    always @(posedge clk) begin
        rst_q <= rst;
        btn_q <= button;
    end

    always @(negedge clk) begin
        if (rst_q) begin
            m_cyc = 0;
            for (int c = 0; c < CH; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_run_val[c] = 0; m_run_len[c] = DEPTH;
                m_level[c] = 0; m_press[c] = 0; m_rel[c] = 0; m_hcnt[c] = 0;
            end
        end else begin
            tick_now = (m_cyc % TICK_DIV) == TICK_DIV - 1;
            for (int c = 0; c < CH; c++) begin
                m_press[c] = 0;
                m_rel[c]   = 0;
                if (tick_now) begin
                    if (m_s2[c] == m_run_val[c]) begin
                        if (m_run_len[c] < DEPTH) m_run_len[c]++;
                    end else begin
                        m_run_val[c] = m_s2[c];
                        m_run_len[c] = 1;
                    end
                    was = m_level[c];
                    if (m_run_len[c] >= DEPTH && m_run_val[c] != was) begin
                        m_level[c] = m_run_val[c];
                        if (m_level[c]) m_press[c] = 1; else m_rel[c] = 1;
                    end
                    if (was && m_level[c] && m_hcnt[c] < HOLD_TICKS) m_hcnt[c]++;
                end
                if (!m_level[c]) m_hcnt[c] = 0;
                m_s2[c] = m_s1[c];
                m_s1[c] = btn_q[c];
            end
            m_cyc++;
        end
        for (int c = 0; c < CH; c++) begin
            e_level[c] = m_level[c];
            e_press[c] = m_press[c];
            e_rel[c]   = m_rel[c];
            e_hold[c]  = (m_hcnt[c] == HOLD_TICKS) && HOLD_ON[0];
        end
        chk("model_level", level, e_level);
        chk("model_press", press, e_press);
        chk("model_release", release_pulse, e_rel);
        chk("model_hold", hold, e_hold);
        chk("model_tick", tick, !rst && ((m_cyc % TICK_DIV) == TICK_DIV - 1));
    end

    int            found;
    int            p0, p1, both, partial;
    logic [CH-1:0] seen;
    logic [CH-1:0] target;
    int            bounce_left[CH];

    initial begin
        rst    = 1'b1;
        button = 2'b11;
        repeat (3) step();
        chk("rst_level", level, 0);
        chk("rst_press", press, 0);
        chk("rst_release", release_pulse, 0);
        chk("rst_hold", hold, 0);
        chk("rst_tick", tick, 0);
        rst = 1'b0;
        #1;
        chk("tick_c0", tick, 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("tick_first", tick, (k == 3));
        end
        repeat (13) step();
        chk("first_level", level, 2'b11);
        chk("first_press", press, 2'b11);
        step();
        chk("first_press_gone", press, 2'b00);
        chk("first_level_kept", level, 2'b11);
        repeat (10) step();
        chk("hold_pre", hold, 2'b00);
        step();
        chk("hold_set", hold, HOLD_ON);

        // Reset while pressed and held.
        rst = 1'b1;
        step();
        chk("midrst_level", level, 0);
        chk("midrst_hold", hold, 0);
        chk("midrst_release", release_pulse, 0);
        rst   = 1'b0;
        found = -1;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk("midrst_no_release", release_pulse, 0);
            if (press[0] && found < 0) found = k;
        end
        chk("midrst_press_edge", found, 16);

        button = 2'b00;
        repeat (24) step();
        chk("released_level", level, 0);

        // Clean press on channel 0 only, then hold and drop.
        button = 2'b01;
        p0 = 0; p1 = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (press[0]) p0++;
            if (press[1]) p1++;
        end
        chk("clean_press0_count", p0, 1);
        chk("clean_press1_count", p1, 0);
        chk("clean_level", level, 2'b01);
        button = 2'b00;
        repeat (24) step();
        chk("drop_level", level, 0);

        // Bounce: toggling every 6 clk never yields DEPTH identical samples.
        seen = '0;
        for (int t = 0; t < 60; t++) begin
            if (t % 6 == 0) button[0] = ~button[0];
            step();
            seen |= press | release_pulse | level;
        end
        button = 2'b00;
        repeat (24) begin
            step();
            seen |= press | release_pulse | level;
        end
        chk("bounce_activity", seen, 0);

        // Simultaneous channels.
        button = 2'b11;
        both = 0; partial = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (press == 2'b11) both++;
            else if (press != 2'b00) partial++;
        end
        chk("simul_both", both, 1);
        chk("simul_partial", partial, 0);
        chk("simul_level", level, 2'b11);

        // Randomized bouncing traffic with occasional resets.
        target = 2'b00;
        for (int c = 0; c < CH; c++) bounce_left[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 39) == 0) begin
                    target[c]      = ~target[c];
                    bounce_left[c] = $urandom_range(0, 12);
                end
                if (bounce_left[c] > 0) begin
                    button[c] = 1'($urandom_range(0, 1));
                    bounce_left[c]--;
                end else begin
                    button[c] = target[c];
                end
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst    = 1'b0;
        button = 2'b00;
        repeat (24) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
